// File: rtl/relay_pkg.sv
// Shared types and constants for the relay ALU: function codes, FSM states
// and the default relay settle time.
package relay_pkg;

    typedef enum logic [2:0] {
        FN_ADD = 3'b000,
        FN_INC = 3'b001,
        FN_AND = 3'b010,
        FN_OR  = 3'b011,
        FN_XOR = 3'b100,
        FN_NOT = 3'b101,
        FN_SHL = 3'b110,
        FN_CLR = 3'b111
    } alu_fn_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } alu_state_e;

    localparam int ALU_SETTLE_DEFAULT = 3;

endpackage

// File: rtl/relay_alu_core.sv
// Combinational ALU function: maps (fn, B, C) to {carry, result}.
// Flags other than carry are derived by the caller from the result.
module relay_alu_core
    import relay_pkg::*;
#(
    parameter int N = 8
) (
    input  alu_fn_e        fn,
    input  logic [N-1:0]   b,
    input  logic [N-1:0]   c,
    output logic [N-1:0]   result,
    output logic           carry
);

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (fn)
            FN_ADD: {carry, result} = {1'b0, b} + {1'b0, c};
            FN_INC: {carry, result} = {1'b0, b} + (N+1)'(1);
            FN_AND: result = b & c;
            FN_OR:  result = b | c;
            FN_XOR: result = b ^ c;
            FN_NOT: result = ~b;
            // Rotate left: the bit leaving the top re-enters at bit 0 and also lands in carry.
            FN_SHL: begin
                result = {b[N-2:0], b[N-1]};
                carry  = b[N-1];
            end
            FN_CLR: result = '0;
            default: begin
                result = '0;
                carry  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/relay_alu.sv
// Relay ALU wrapper: latches operands on start, waits SETTLE cycles for the
// relays to settle, then registers result and flags and pulses done.
module relay_alu
    import relay_pkg::*;
#(
    parameter int N      = 8,
    parameter int SETTLE = ALU_SETTLE_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] b_in,
    input  logic [N-1:0] c_in,
    input  logic [2:0]   fn,
    input  logic         start,
    input  logic         sel_alu,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         carry,
    output logic         zero,
    output logic         sign,
    output logic [N-1:0] bus_out,
    output logic         bus_drive,
    output logic         led_busy
);

    localparam int CW = 4;

    alu_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0] b_q, b_d, c_q, c_d;
    alu_fn_e      fn_q, fn_d;
    logic [N-1:0] result_q, result_d;
    logic         carry_q, carry_d, zero_q, zero_d, sign_q, sign_d;
    logic         done_q, done_d;

    logic [N-1:0] core_result;
    logic         core_carry;

    relay_alu_core #(.N(N)) u_core (
        .fn     (fn_q),
        .b      (b_q),
        .c      (c_q),
        .result (core_result),
        .carry  (core_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_SETTLE;
            ST_SETTLE: if (cnt_q == '0) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath next-state: operand latch, settle countdown, result capture.
    always_comb begin
        cnt_d    = cnt_q;
        b_d      = b_q;
        c_d      = c_q;
        fn_d     = fn_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        sign_d   = sign_q;
        // done is registered off the DONE state so it lands SETTLE+1 edges after start.
        done_d   = (state_q == ST_DONE);
        case (state_q)
            ST_IDLE: if (start) begin
                b_d   = b_in;
                c_d   = c_in;
                fn_d  = alu_fn_e'(fn);
                cnt_d = CW'(SETTLE - 1);
            end
            ST_SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    result_d = core_result;
                    carry_d  = core_carry;
                    zero_d   = (core_result == '0);
                    sign_d   = core_result[N-1];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            b_q      <= '0;
            c_q      <= '0;
            fn_q     <= FN_ADD;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            sign_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            b_q      <= b_d;
            c_q      <= c_d;
            fn_q     <= fn_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            sign_q   <= sign_d;
            done_q   <= done_d;
        end
    end

    // The bus path never waits on busy; it always shows the last completed result.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        led_busy  = busy;
        done      = done_q;
        result    = result_q;
        carry     = carry_q;
        zero      = zero_q;
        sign      = sign_q;
        bus_drive = sel_alu;
        bus_out   = sel_alu ? result_q : '0;
    end

endmodule

// File: tb/tb_relay_alu.sv
// Scoreboard bench for relay_alu: driver pushes expected responses from an
// arithmetic reference model, a negedge monitor pops and compares on done.
module tb_relay_alu;

    localparam int N      = 8;
    localparam int SETTLE = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] b_in, c_in;
    logic [2:0]   fn;
    logic         start, sel_alu;
    logic         busy, done, carry, zero, sign, bus_drive, led_busy;
    logic [N-1:0] result, bus_out;

    relay_alu #(.N(N), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .b_in(b_in), .c_in(c_in), .fn(fn),
        .start(start), .sel_alu(sel_alu), .busy(busy), .done(done),
        .result(result), .carry(carry), .zero(zero), .sign(sign),
        .bus_out(bus_out), .bus_drive(bus_drive), .led_busy(led_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] r;
        logic         c, z, s;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   done_cnt = 0;
    int   last_r = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model written from the function table with integer arithmetic.
    function automatic exp_t model(input int f, input int b, input int c);
        exp_t e;
        int r, cy;
        cy = 0;
        case (f)
            0: begin r = b + c; cy = (r >= 256) ? 1 : 0; end
            1: begin r = b + 1; cy = (r >= 256) ? 1 : 0; end
            2: r = b & c;
            3: r = b | c;
            4: r = b ^ c;
            5: r = 255 - b;
            6: begin cy = b / 128; r = (b * 2) % 256 + cy; end
            default: r = 0;
        endcase
        r   = r % 256;
        e.r = r[N-1:0];
        e.c = (cy != 0);
        e.z = (r == 0);
        e.s = (r >= 128);
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            done_cnt++;
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", result, e.r);
                chk("carry",  carry,  e.c);
                chk("zero",   zero,   e.z);
                chk("sign",   sign,   e.s);
            end
        end
    end

    // One operation: start sampled at "edge 0", then count edges until done.
    task automatic run_op(input int f, input int b, input int c, input bit noise, input bit bus);
        exp_t e;
        int   lat, dc0;
        bit   seen;
        e = model(f, b, c);
        @(posedge clk); #1;
        b_in = b[N-1:0]; c_in = c[N-1:0]; fn = f[2:0]; start = 1'b1;
        q.push_back(e);
        dc0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b0;
        if (noise) begin
            b_in = 8'h55; c_in = N'($urandom); fn = 3'($urandom);
        end
        lat = 0; seen = 0;
        while (lat < 20) begin
            if (done) begin seen = 1; break; end
            if (lat == 1) begin
                chk("busy_mid", busy, 1);
                chk("led_busy_mid", led_busy, 1);
                if (noise) start = 1'b1;
                if (bus) begin
                    sel_alu = 1'b1; #1;
                    chk("bus_prior", bus_out, last_r);
                    chk("bus_drive_hi", bus_drive, 1);
                end
            end
            if (lat == 2) start = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        chk("done_seen", seen, 1);
        chk("latency", lat, SETTLE + 1);
        if (bus) chk("bus_new", bus_out, e.r);
        last_r = e.r;
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
        chk("idle_after", busy, 0);
        chk("one_done", done_cnt, dc0 + 1);
        if (bus) begin
            sel_alu = 1'b0; #1;
            chk("bus_off", bus_out, 0);
            chk("bus_drive_lo", bus_drive, 0);
        end
    endtask

    initial begin
        int dc0;
        rst = 1'b1; start = 1'b0; sel_alu = 1'b0;
        b_in = '0; c_in = '0; fn = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {carry, zero, sign}, 0);
        chk("rst_bus", bus_out, 0);
        @(negedge clk); rst = 1'b0;

        run_op(0, 8'h7F, 8'h01, 0, 0);
        run_op(0, 8'hFF, 8'h01, 0, 0);
        run_op(6, 8'h81, 8'h00, 0, 0);
        run_op(5, 8'hFF, 8'h00, 0, 0);
        run_op(1, 8'h0F, 8'h00, 1, 0);
        run_op(0, 8'h12, 8'h34, 0, 0);

        // Reset one cycle into SETTLE kills the operation without a done.
        @(posedge clk); #1;
        b_in = 8'h11; c_in = 8'h22; fn = 3'b000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        dc0 = done_cnt;
        rst = 1'b1; #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_result", result, 0);
        chk("rst_mid_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        last_r = 0;
        repeat (8) @(posedge clk);
        #1;
        chk("no_done_after_rst", done_cnt, dc0);

        run_op(2, 8'hF0, 8'h3C, 0, 0);
        run_op(4, 8'hAA, 8'h0F, 0, 1);
        run_op(7, 8'h99, 8'h77, 0, 0);

        for (int i = 0; i < 25; i++)
            run_op($urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255),
                   bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));

        repeat (3) @(posedge clk);
        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
